mem_port_arbiter: RTL and testbench

- Shares one single-port memory between instruction fetch (port F) and the load/store path (port D).
- Accepts one request at a time and holds one outstanding memory transaction.
- Returns the response to the owning port only.
- Sits between the fetch stage / execute-stage LSU and the memory bus; lets fetch and data share a unified memory without corrupting either stream.

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (F) and load/store (D), one transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic                f_kill,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                kill_q, kill_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic                idle, grant, f_win, d_win;
  // owner_q: 1 = D owns the transaction, 0 = F
  assign idle  = state_q == IDLE;
  assign f_win = f_req && (!d_req || starve_q == LIM);
  assign d_win = d_req && !f_win;
  assign grant = idle && (f_req || d_req);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      kill_q      <= 1'b0;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end
  always_comb begin
    state_d     = grant ? REQ :
                  (state_q == REQ && mem_gnt) ? RESP :
                  (state_q == RESP && mem_rvalid) ? IDLE : state_q;
    owner_d     = grant ? d_win : owner_q;
    mem_addr_d  = grant ? (d_win ? d_addr : f_addr) : mem_addr_q;
    mem_we_d    = grant ? d_win && d_we : mem_we_q;
    mem_wdata_d = grant ? (d_win ? d_wdata : '0) : mem_wdata_q;
    mem_wstrb_d = grant ? (d_win ? d_wstrb : '0) : mem_wstrb_q;
    // a kill only sticks to an F-owned transaction and dies with it
    kill_d      = (state_d == IDLE) ? 1'b0 : kill_q || (f_kill && !owner_d);
    starve_d    = f_gnt ? '0 : (f_req && starve_q != LIM) ? starve_q + CNT_W'(1) : starve_q;
  end
  always_comb begin
    f_gnt     = idle && f_win;
    d_gnt     = idle && d_win;
    f_rvalid  = state_q == RESP && mem_rvalid && !owner_q && !kill_q;
    d_rvalid  = state_q == RESP && mem_rvalid && owner_q;
    f_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    mem_req   = state_q == REQ;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wstrb = mem_wstrb_q;
    busy      = !idle;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors plus directed sequences; a scoreboard checks every response against a reference memory.
module tb_mem_port_arbiter;
  logic clk, rst;
  logic f_req, f_kill, f_gnt, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0] d_wstrb, mem_wstrb;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int checks = 0, errors = 0;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_arr [logic [31:0]];
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction
  function logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction
  function logic [31:0] ref_rd(input logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_val(a);
  endfunction
  int gnt_wait = 0, rv_wait = 1, gw_cnt = 0, rv_cnt = 0;
  bit pend_rv = 0, in_req = 0;
  logic [31:0] resp;
  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0;
      if (rst) in_req = 0;
      if (pend_rv) begin
        if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = resp; pend_rv = 0; end
        else rv_cnt--;
      end else if (mem_req) begin
        if (!in_req) begin in_req = 1; gw_cnt = gnt_wait; end
        if (gw_cnt == 0) begin
          mem_gnt = 1; in_req = 0; pend_rv = 1; rv_cnt = rv_wait - 1;
          resp = mem_we ? 32'h0BAD0ACE : mem_rd(mem_addr);
          if (mem_we) mem_arr[mem_addr] = merge(mem_rd(mem_addr), mem_wdata, mem_wstrb);
        end else gw_cnt--;
      end
    end
  end
  always @(negedge clk)
    if (!rst && mem_req && mem_gnt)
      assert (!mem_rvalid) else $error("FAIL illegal memory response: mem_gnt with mem_rvalid in REQ");
  typedef struct { bit d; bit we; bit kill; logic [31:0] data; } exp_t;
  exp_t q[$];
  exp_t e;
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (q.size() > 0) chk("gnt_while_outstanding", {f_gnt, d_gnt}, 2'b00);
      if (mem_rvalid && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_f_rvalid", f_rvalid, !e.d && !e.kill);
        chk("sb_d_rvalid", d_rvalid, e.d);
        if (!e.we && !e.kill) chk("sb_rdata", e.d ? d_rdata : f_rdata, e.data);
      end else chk("no_spurious_rvalid", {f_rvalid, d_rvalid}, 2'b00);
      if (f_kill && q.size() > 0 && !q[q.size()-1].d) q[q.size()-1].kill = 1;
      if (f_gnt) q.push_back('{d: 0, we: 0, kill: f_kill, data: ref_rd(f_addr)});
      if (d_gnt) begin
        q.push_back('{d: 1, we: d_we, kill: 0, data: d_we ? 32'h0 : ref_rd(d_addr)});
        if (d_we) ref_arr[d_addr] = merge(ref_rd(d_addr), d_wdata, d_wstrb);
      end
    end
  end
  task tick();
    @(posedge clk); #1;
  endtask
  task chk_rst_outs(input string tag);
    chk({tag, "_ctrl"}, {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_req, mem_we, busy}, 7'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_wstrb"}, mem_wstrb, 4'h0);
  endtask
  task do_reset();
    tick(); rst = 1; f_req = 0; d_req = 0; f_kill = 0; d_we = 0;
    tick(); @(negedge clk); chk_rst_outs("reset");
    tick(); rst = 0; @(negedge clk);
  endtask
  task wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin tick(); @(negedge clk); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask
  typedef struct {
    logic f, d, we; logic [31:0] fa, da, wd; logic [3:0] ws;
    logic ef, ed, emwe; logic [31:0] eaddr; logic [3:0] ews;
  } vec_t;
  vec_t vt[6];
  int c, np;
  initial begin
    rst = 1; f_req = 0; f_addr = 0; f_kill = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    vt[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,        4'h0, 1, 0, 0, 32'h100, 4'h0};
    vt[1] = '{0, 1, 0, 32'h0,   32'h300, 32'h0,        4'hF, 0, 1, 0, 32'h300, 4'hF};
    vt[2] = '{0, 1, 1, 32'h0,   32'h200, 32'h12345678, 4'hF, 0, 1, 1, 32'h200, 4'hF};
    vt[3] = '{1, 1, 1, 32'h108, 32'h204, 32'hCAFEF00D, 4'h3, 0, 1, 1, 32'h204, 4'h3};
    vt[4] = '{0, 0, 0, 32'h110, 32'h400, 32'h0,        4'hF, 0, 0, 0, 32'h0,   4'h0};
    vt[5] = '{1, 0, 1, 32'h10C, 32'h500, 32'h55555555, 4'hF, 1, 0, 0, 32'h10C, 4'h0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      tick();
      f_req = vt[i].f; d_req = vt[i].d; d_we = vt[i].we; f_addr = vt[i].fa;
      d_addr = vt[i].da; d_wdata = vt[i].wd; d_wstrb = vt[i].ws;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), {f_gnt, d_gnt}, {vt[i].ef, vt[i].ed});
      tick(); f_req = 0; d_req = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_req", i), mem_req, vt[i].ef | vt[i].ed);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vt[i].emwe);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].eaddr);
      chk($sformatf("vec%0d_mem_wstrb", i), mem_wstrb, vt[i].ews);
      if (vt[i].emwe) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].wd);
      wait_idle();
    end
    // F-only read, minimum latency
    do_reset();
    tick(); f_req = 1; f_addr = 32'h100;
    @(negedge clk); chk("f_only_gnt", {f_gnt, d_gnt}, 2'b10);
    tick(); f_req = 0;
    @(negedge clk); chk("f_only_mem_req_c1", mem_req, 1'b1);
    tick(); @(negedge clk);
    chk("f_only_mem_req_c2", mem_req, 1'b0);
    chk("f_only_rvalid", {f_rvalid, d_rvalid}, 2'b10);
    chk("f_only_rdata", f_rdata, 32'hDEADBEEF);
    tick(); @(negedge clk); chk("f_only_busy_c3", busy, 1'b0);
    // both request: D write wins, F follows at next IDLE and reads the new data
    do_reset();
    tick(); f_req = 1; f_addr = 32'h200; d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    @(negedge clk); chk("both_gnt", {f_gnt, d_gnt}, 2'b01);
    tick(); d_req = 0;
    @(negedge clk); chk("both_mem_we", mem_we, 1'b1); chk("both_mem_wdata", mem_wdata, 32'h12345678);
    c = 1;
    do begin tick(); @(negedge clk); c++; end while (!f_gnt && c < 20);
    chk("both_f_gnt_cycle", c, 3);
    tick(); f_req = 0; @(negedge clk); wait_idle();
    // starvation: D held continuously, F forced through when the counter saturates
    do_reset();
    tick(); d_req = 1; d_we = 0; d_addr = 32'h300; f_req = 1; f_addr = 32'h104;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_c%0d_gnt", k), {f_gnt, d_gnt}, {k == 6, k == 0 || k == 3 || k == 9});
      tick();
      if (k == 6) f_req = 0;
    end
    d_req = 0; @(negedge clk); wait_idle();
    // kill during RESP suppresses f_rvalid
    do_reset();
    rv_wait = 4;
    tick(); f_req = 1; f_addr = 32'h104;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("kill_c%0d_f_rvalid", k), f_rvalid, 1'b0);
      chk($sformatf("kill_c%0d_busy", k), busy, k > 0 && k < 6);
      tick();
      if (k == 0) f_req = 0;
      f_kill = (k == 1);
    end
    rv_wait = 1;
    f_req = 1; f_addr = 32'h100;
    @(negedge clk); chk("kill_next_gnt", f_gnt, 1'b1);
    np = 0;
    for (int k = 0; k < 6; k++) begin tick(); f_req = 0; @(negedge clk); if (f_rvalid) np++; end
    chk("kill_next_rvalid_count", np, 1);
    // f_kill while D owns the transaction has no effect
    tick(); d_req = 1; d_we = 0; d_addr = 32'h300;
    @(negedge clk); chk("dkill_gnt", d_gnt, 1'b1);
    tick(); d_req = 0; f_kill = 1;
    tick(); f_kill = 0;
    @(negedge clk); wait_idle();
    // mem_gnt withheld: request fields stay stable, no new grants
    do_reset();
    gnt_wait = 5;
    tick(); d_req = 1; d_we = 1; d_addr = 32'h208; d_wdata = 32'hAABBCCDD; d_wstrb = 4'h5; f_req = 1; f_addr = 32'h208;
    @(negedge clk); chk("hold_d_gnt", d_gnt, 1'b1);
    tick(); d_req = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d_req", k), {mem_req, mem_we, f_gnt, d_gnt}, 4'b1100);
      chk($sformatf("hold_c%0d_addr", k), mem_addr, 32'h208);
      chk($sformatf("hold_c%0d_wdata", k), mem_wdata, 32'hAABBCCDD);
      chk($sformatf("hold_c%0d_wstrb", k), mem_wstrb, 4'h5);
      tick();
    end
    gnt_wait = 0;
    c = 6;
    @(negedge clk);
    while (!f_gnt && c < 30) begin tick(); @(negedge clk); c++; end
    chk("hold_f_gnt_cycle", c, 8);
    tick(); f_req = 0; @(negedge clk); wait_idle();
    // reset during RESP, then a stale mem_rvalid
    do_reset();
    rv_wait = 3;
    tick(); f_req = 1; f_addr = 32'h100;
    @(negedge clk); chk("rstmid_gnt", f_gnt, 1'b1);
    tick(); f_req = 0;
    tick(); rst = 1;
    @(negedge clk); chk("rstmid_busy_resp", busy, 1'b1);
    tick(); rst = 0;
    @(negedge clk); chk_rst_outs("rstmid");
    tick(); @(negedge clk);
    chk("rstmid_stale_seen", mem_rvalid, 1'b1);
    chk("rstmid_stale_ignored", {f_rvalid, d_rvalid, busy}, 3'b000);
    rv_wait = 1;
    tick(); d_req = 1; d_we = 0; d_addr = 32'h200;
    @(negedge clk); chk("rstmid_next_gnt", d_gnt, 1'b1);
    tick(); d_req = 0; @(negedge clk); wait_idle();
    tick(); @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
